// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery channel of the serial receiver.
//   data  - received byte, meaningful while valid=1
//   valid - a byte is held and offered to the consumer
//   ready - consumer accepts; a transfer happens on valid && ready at posedge
// master: the receiver (drives data/valid); slave: the consumer (drives ready).
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: serial receiver for the 10-bit frame of uart_tx
// (start=0, 8 data bits MSB first, stop=1), same clock domain.
// Ports:
//   CLK       - clock, all logic on posedge
//   RESETN    - synchronous active-low reset
//   rx        - serial line, idles high, already in the CLK domain
//   bus       - uart_rx_if.master: data/valid out, ready in, one-entry holding register
//   frame_err - one-cycle pulse when a stop bit is sampled low
//   overrun   - one-cycle pulse when a byte completes while the holding register is full
//   busy      - high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        rx,
   uart_rx_if.master   bus,
   output logic        frame_err,
   output logic        overrun,
   output logic        busy
);

   // Mid-bit sample offset measured from the start-bit detection edge.
   localparam int unsigned M        = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_LAST = CLKS_PER_BIT - 1;
   localparam int unsigned MID_LAST = (M > 0) ? M - 1 : 0;

   localparam logic [CNT_W-1:0] CNT_BIT_LAST = CNT_W'(BIT_LAST);
   localparam logic [CNT_W-1:0] CNT_MID_LAST = CNT_W'(MID_LAST);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bitn_q, bitn_d;
   logic [7:0]       sreg_q, sreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             bit_end_c;

   // Last clock of a serial bit period: this edge is the sample point.
   assign bit_end_c = (cnt_q == CNT_BIT_LAST);

   // State register.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitn_d      = bitn_q;
      sreg_d      = sreg_q;
      data_d      = data_q;
      // A completed transfer empties the holding register unless a byte loads below.
      valid_d     = valid_q & ~bus.ready;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx) begin
               // With no mid-bit offset the detection edge is already the start sample.
               if (M == 0) begin
                  state_d = S_DATA;
                  bitn_d  = 3'd7;
               end else begin
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            if (cnt_q == CNT_MID_LAST) begin
               cnt_d = '0;
               if (rx) begin
                  // Line went back high before mid-bit: glitch, not a start.
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bitn_d  = 3'd7;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_DATA: begin
            if (bit_end_c) begin
               cnt_d  = '0;
               sreg_d = {sreg_q[6:0], rx};
               if (bitn_q == 3'd0) begin
                  state_d = S_STOP;
               end else begin
                  bitn_d = bitn_q - 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_STOP: begin
            if (bit_end_c) begin
               cnt_d = '0;
               if (rx) begin
                  // Straight to IDLE so a start bit on the next clock is caught.
                  state_d = S_IDLE;
                  if (!valid_q || bus.ready) begin
                     data_d  = sreg_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_BREAK: begin
            // A held-low line is a break, never a new start.
            cnt_d = '0;
            if (rx) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         cnt_q       <= '0;
         bitn_q      <= 3'd0;
         sreg_q      <= 8'd0;
         data_q      <= 8'd0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bitn_q      <= bitn_d;
         sreg_q      <= sreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.data  = data_q;
   assign bus.valid = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames into uart_rx at 1 and 4 clocks/bit,
// checked every cycle against a frame-timing reference model.
module tb_uart_rx;

   logic CLK;
   logic RESETN;
   logic rx;
   logic ready;
   logic sel;

   logic rx1, rx4;
   logic fe1, ov1, busy1;
   logic fe4, ov4, busy4;

   uart_rx_if bus1();
   uart_rx_if bus4();

   assign rx1        = sel ? 1'b1 : rx;
   assign rx4        = sel ? rx : 1'b1;
   assign bus1.ready = sel ? 1'b1 : ready;
   assign bus4.ready = sel ? ready : 1'b1;

   uart_rx #(.CLKS_PER_BIT(1)) dut1 (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .rx        (rx1),
      .bus       (bus1),
      .frame_err (fe1),
      .overrun   (ov1),
      .busy      (busy1)
   );

   uart_rx #(.CLKS_PER_BIT(4)) dut4 (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .rx        (rx4),
      .bus       (bus4),
      .frame_err (fe4),
      .overrun   (ov4),
      .busy      (busy4)
   );

   logic [7:0] o_data;
   logic       o_valid, o_fe, o_ov, o_busy;
   assign o_data  = sel ? bus4.data  : bus1.data;
   assign o_valid = sel ? bus4.valid : bus1.valid;
   assign o_fe    = sel ? fe4   : fe1;
   assign o_ov    = sel ? ov4   : ov1;
   assign o_busy  = sel ? busy4 : busy1;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int    n_assert = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   string phase    = "init";

   // Reference model: frame position measured in clocks since the start-bit edge.
   int         cpb = 1;
   int         mm  = 0;
   int         m_mode = 0;   // 0 idle, 1 in frame, 2 break
   int         m_t = 0;
   logic [7:0] m_bits = 8'd0;
   logic [7:0] e_data = 8'd0;
   logic       e_valid = 1'b0, e_fe = 1'b0, e_ov = 1'b0, e_busy = 1'b0;

   int   t_start = 0;
   int   t_rise  = 0;
   logic prev_valid = 1'b0;

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s cycle %0d: observed %h expected %h", phase, tag, cyc, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s cycle %0d: observed %b expected %b", phase, tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s cycle %0d: observed %0d expected %0d", phase, tag, cyc, obs, exp);
      end
   endtask

   // Apply one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      logic v_before;
      int   k;
      if (!RESETN) begin
         m_mode = 0; m_t = 0; m_bits = 8'd0;
         e_data = 8'd0; e_valid = 1'b0; e_fe = 1'b0; e_ov = 1'b0; e_busy = 1'b0;
         return;
      end
      v_before = e_valid;
      e_fe = 1'b0;
      e_ov = 1'b0;
      if (e_valid && ready) e_valid = 1'b0;
      case (m_mode)
         0: begin
            if (rx == 1'b0) begin
               m_mode = 1;
               m_t    = 0;
            end
         end
         1: begin
            m_t++;
            if (mm > 0 && m_t == mm) begin
               if (rx) m_mode = 0;
            end else if (m_t == mm + 9 * cpb) begin
               if (rx) begin
                  m_mode = 0;
                  if (!v_before || ready) begin
                     e_data  = m_bits;
                     e_valid = 1'b1;
                  end else begin
                     e_ov = 1'b1;
                  end
               end else begin
                  e_fe   = 1'b1;
                  m_mode = 2;
               end
            end else if (m_t > mm && ((m_t - mm) % cpb) == 0) begin
               k = (m_t - mm) / cpb;
               m_bits[8 - k] = rx;
            end
         end
         default: begin
            if (rx) m_mode = 0;
         end
      endcase
      e_busy = (m_mode != 0);
   endtask

   task automatic tick();
      @(posedge CLK);
      cyc++;
      model_edge();
      #1;
      check1("valid", o_valid, e_valid);
      check8("data", o_data, e_data);
      check1("frame_err", o_fe, e_fe);
      check1("overrun", o_ov, e_ov);
      check1("busy", o_busy, e_busy);
      if (o_valid && !prev_valid) t_rise = cyc;
      prev_valid = o_valid;
   endtask

   task automatic drive_bit(input logic b, input bit rnd);
      rx = b;
      repeat (cpb) begin
         if (rnd) ready = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input bit rnd);
      t_start = cyc + 1;
      drive_bit(1'b0, rnd);
      for (int i = 7; i >= 0; i--) drive_bit(b[i], rnd);
      drive_bit(stop, rnd);
   endtask

   task automatic select_dut(input logic s);
      sel    = s;
      cpb    = s ? 4 : 1;
      mm     = (cpb - 1) / 2;
      rx     = 1'b1;
      ready  = 1'b1;
      RESETN = 1'b0;
      repeat (2) tick();
      RESETN = 1'b1;
      tick();
   endtask

   task automatic random_frames(input int n);
      logic [7:0] b;
      logic       stop;
      int         gap;
      for (int f = 0; f < n; f++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         send_frame(b, stop, 1'b1);
         gap = $urandom_range(0, 2) + (stop ? 0 : 1);
         rx  = 1'b1;
         for (int g = 0; g < gap; g++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      ready = 1'b1;
      rx    = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      RESETN = 1'b0;
      rx     = 1'b1;
      ready  = 1'b1;
      sel    = 1'b0;

      // 1: single frame 0xA5 at one clock per bit
      phase = "t1";
      select_dut(1'b0);
      check1("rst_valid", o_valid, 1'b0);
      check8("rst_data", o_data, 8'h00);
      check1("rst_busy", o_busy, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0);
      rx = 1'b1;
      check1("a5_valid", o_valid, 1'b1);
      check8("a5_data", o_data, 8'hA5);
      check_int("a5_latency", t_rise - t_start, 9);
      tick();
      check1("a5_one_cycle", o_valid, 1'b0);

      // 2: back-to-back 0x00 then 0xFF
      phase = "t2";
      send_frame(8'h00, 1'b1, 1'b0);
      check8("b2b_first", o_data, 8'h00);
      check1("b2b_first_v", o_valid, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b0);
      check8("b2b_second", o_data, 8'hFF);
      check_int("b2b_latency", t_rise - t_start, 9);
      rx = 1'b1;
      tick();

      // 3: overrun with consumer stalled
      phase = "t3";
      ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0);
      check8("ovr_data_kept", o_data, 8'h3C);
      check1("ovr_valid", o_valid, 1'b1);
      check1("ovr_pulse", o_ov, 1'b1);
      rx = 1'b1;
      tick();
      check1("ovr_pulse_end", o_ov, 1'b0);
      ready = 1'b1;
      tick();
      check1("ovr_drain", o_valid, 1'b0);

      // 4: bad stop bit, held break, then a good frame
      phase = "t4";
      send_frame(8'h55, 1'b0, 1'b0);
      check1("fe_pulse", o_fe, 1'b1);
      check1("fe_no_valid", o_valid, 1'b0);
      rx = 1'b0;
      repeat (5) tick();
      check1("brk_busy", o_busy, 1'b1);
      rx = 1'b1;
      tick();
      check1("brk_exit", o_busy, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0);
      check8("after_brk_data", o_data, 8'h12);
      check1("after_brk_valid", o_valid, 1'b1);
      rx = 1'b1;
      tick();

      // 5: reset in the middle of frame 0x81
      phase = "t5";
      rx = 1'b0; tick();
      rx = 1'b1; tick();
      rx = 1'b0; tick();
      rx = 1'b0; tick();
      RESETN = 1'b0;
      rx     = 1'b0;
      tick();
      check1("mid_rst_busy", o_busy, 1'b0);
      check1("mid_rst_valid", o_valid, 1'b0);
      RESETN = 1'b1;
      rx     = 1'b1;
      tick();
      send_frame(8'h81, 1'b1, 1'b0);
      check8("post_rst_data", o_data, 8'h81);
      rx = 1'b1;
      tick();

      phase = "rand1";
      random_frames(25);

      // 6: four clocks per bit
      phase = "t6";
      select_dut(1'b1);
      rx = 1'b0;
      tick();
      check1("glitch_start", o_busy, 1'b1);
      rx = 1'b1;
      tick();
      check1("glitch_reject", o_busy, 1'b0);
      repeat (3) tick();
      check1("glitch_no_valid", o_valid, 1'b0);
      send_frame(8'h96, 1'b1, 1'b0);
      check8("cpb4_data", o_data, 8'h96);
      check_int("cpb4_latency", t_rise - t_start, 37);
      rx = 1'b1;
      tick();

      phase = "rand4";
      random_frames(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
